// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types, widths and helpers for the alarm controller
//
// Purpose: state encoding, hour/minute field widths and limits, and a
//          counter-width helper used by alarm_controller and alarm_time_reg.
// Ports:   none (package).

package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_time_reg.sv
// rtl/alarm_time_reg.sv - stored alarm time with gated, wrapping increments
//
// Purpose: holds the user-set alarm hour and minute. Increments are applied
//          only while edit_en is high; hour wraps 23->0, minute wraps 59->0
//          without carrying into the hour. Both increments may land together.
// Ports:
//   CLK      in  1      system clock
//   RST      in  1      asynchronous active-high reset, loads HR_DEF/MIN_DEF
//   edit_en  in  1      increments accepted when high
//   inc_hr   in  1      one-cycle pulse, increment hour
//   inc_min  in  1      one-cycle pulse, increment minute
//   alm_hr   out HR_W   stored alarm hour
//   alm_min  out MIN_W  stored alarm minute

module alarm_time_reg
  import alarm_pkg::*;
#(
  parameter int HR_DEF  = 7,
  parameter int MIN_DEF = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             edit_en,
  input  logic             inc_hr,
  input  logic             inc_min,
  output logic [HR_W-1:0]  alm_hr,
  output logic [MIN_W-1:0] alm_min
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alm_hr  <= HR_W'(HR_DEF);
      alm_min <= MIN_W'(MIN_DEF);
    end else if (edit_en) begin
      if (inc_hr)
        alm_hr <= (alm_hr == HR_MAX) ? '0 : alm_hr + HR_W'(1);
      if (inc_min)
        alm_min <= (alm_min == MIN_MAX) ? '0 : alm_min + MIN_W'(1);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm arm/ring/snooze/dismiss sequencer
//
// Purpose: compares the running time against the stored alarm time, rings on
//          the rising edge of a match, and times ring and snooze intervals on
//          the 1 Hz tick. Feeds alarmFlag to the LED blinker and the stored
//          alarm time to the display mux.
// Ports:
//   CLK          in  1  system clock
//   RST          in  1  asynchronous active-high reset
//   tick_1hz     in  1  one-CLK pulse per second
//   cur_hr       in  5  current hour 0-23
//   cur_min      in  6  current minute 0-59
//   arm_sw       in  1  level, 1 = alarm enabled
//   inc_hr       in  1  pulse, increment alarm hour (IDLE/ARMED only)
//   inc_min      in  1  pulse, increment alarm minute (IDLE/ARMED only)
//   snooze_btn   in  1  pulse
//   dismiss_btn  in  1  pulse
//   alarmFlag    out 1  high while ringing
//   alm_hr       out 5  stored alarm hour
//   alm_min      out 6  stored alarm minute
//   armed        out 1  high in ARMED, RINGING or SNOOZE
//   snoozing     out 1  high in SNOOZE

module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int ALARM_HR_DEF   = 7,
  parameter int ALARM_MIN_DEF  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick_1hz,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  input  logic             arm_sw,
  input  logic             inc_hr,
  input  logic             inc_min,
  input  logic             snooze_btn,
  input  logic             dismiss_btn,
  output logic             alarmFlag,
  output logic [HR_W-1:0]  alm_hr,
  output logic [MIN_W-1:0] alm_min,
  output logic             armed,
  output logic             snoozing
);

  localparam int RING_W = cnt_width(RING_SECONDS);
  localparam int SNZ_W  = cnt_width(SNOOZE_SECONDS);
  localparam int NUM_W  = cnt_width(MAX_SNOOZE + 1);

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SECONDS - 1);
  localparam logic [NUM_W-1:0]  SNZ_LIMIT = NUM_W'(MAX_SNOOZE);

  alarm_state_t      state;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snooze_cnt;
  logic [NUM_W-1:0]  snooze_num;
  logic              match;
  logic              match_q;
  logic              trigger;
  logic              snooze_ok;
  logic              edit_en;

  assign match   = (cur_hr == alm_hr) && (cur_min == alm_min);
  // Only the first cycle of a match rings, so a dismissed or timed-out alarm
  // stays quiet for the rest of the matching minute.
  assign trigger = match && !match_q;

  // With MAX_SNOOZE=0 the limit is zero and snooze can never be taken.
  assign snooze_ok = (snooze_num < SNZ_LIMIT);

  assign edit_en = (state == IDLE) || (state == ARMED);

  alarm_time_reg #(
    .HR_DEF  (ALARM_HR_DEF),
    .MIN_DEF (ALARM_MIN_DEF)
  ) u_time_reg (
    .CLK     (CLK),
    .RST     (RST),
    .edit_en (edit_en),
    .inc_hr  (inc_hr),
    .inc_min (inc_min),
    .alm_hr  (alm_hr),
    .alm_min (alm_min)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      snooze_num <= '0;
      match_q    <= 1'b0;
    end else begin
      match_q <= match;
      if (!arm_sw) begin
        // Disarming overrides every button and timeout.
        state      <= IDLE;
        snooze_num <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= ARMED;
            snooze_num <= '0;
          end
          ARMED: begin
            if (trigger) begin
              state      <= RINGING;
              ring_cnt   <= '0;
              snooze_num <= '0;
            end
          end
          RINGING: begin
            if (dismiss_btn) begin
              state      <= ARMED;
              snooze_num <= '0;
            end else if (snooze_btn && snooze_ok) begin
              state      <= SNOOZE;
              snooze_num <= snooze_num + NUM_W'(1);
              snooze_cnt <= '0;
            end else if (tick_1hz) begin
              if (ring_cnt == RING_LAST) begin
                state      <= ARMED;
                snooze_num <= '0;
              end else begin
                ring_cnt <= ring_cnt + RING_W'(1);
              end
            end
          end
          SNOOZE: begin
            if (dismiss_btn) begin
              state      <= ARMED;
              snooze_num <= '0;
            end else if (tick_1hz) begin
              if (snooze_cnt == SNZ_LAST) begin
                state    <= RINGING;
                ring_cnt <= '0;
              end else begin
                snooze_cnt <= snooze_cnt + SNZ_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Moore outputs decoded straight from the state register, so an async
  // reset drops alarmFlag without waiting for a clock edge.
  assign alarmFlag = (state == RINGING);
  assign snoozing  = (state == SNOOZE);
  assign armed     = (state != IDLE);

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - scoreboard bench for alarm_controller

module tb_alarm_controller;

  localparam int RS = 5;
  localparam int SS = 3;
  localparam int MS = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       tick_1hz;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       arm_sw;
  logic       inc_hr;
  logic       inc_min;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       alarmFlag;
  logic [4:0] alm_hr;
  logic [5:0] alm_min;
  logic       armed;
  logic       snoozing;

  alarm_controller #(
    .RING_SECONDS   (RS),
    .SNOOZE_SECONDS (SS),
    .MAX_SNOOZE     (MS),
    .ALARM_HR_DEF   (7),
    .ALARM_MIN_DEF  (0)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .tick_1hz    (tick_1hz),
    .cur_hr      (cur_hr),
    .cur_min     (cur_min),
    .arm_sw      (arm_sw),
    .inc_hr      (inc_hr),
    .inc_min     (inc_min),
    .snooze_btn  (snooze_btn),
    .dismiss_btn (dismiss_btn),
    .alarmFlag   (alarmFlag),
    .alm_hr      (alm_hr),
    .alm_min     (alm_min),
    .armed       (armed),
    .snoozing    (snoozing)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic       af;
    logic       arm;
    logic       snz;
    logic [4:0] hr;
    logic [5:0] mn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic af, input logic arm, input logic snz,
                            input logic [4:0] hr, input logic [5:0] mn);
    exp_t e;
    e.tag = tag; e.af = af; e.arm = arm; e.snz = snz; e.hr = hr; e.mn = mn;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check_val({e.tag, ".alarmFlag"}, 32'(alarmFlag), 32'(e.af));
    check_val({e.tag, ".armed"},     32'(armed),     32'(e.arm));
    check_val({e.tag, ".snoozing"},  32'(snoozing),  32'(e.snz));
    check_val({e.tag, ".alm_hr"},    32'(alm_hr),    32'(e.hr));
    check_val({e.tag, ".alm_min"},   32'(alm_min),   32'(e.mn));
  endtask

  task automatic clk1();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic pulse_inc(input logic h, input logic m);
    inc_hr = h; inc_min = m;
    clk1();
    inc_hr = 1'b0; inc_min = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      clk1();
      tick_1hz = 1'b0;
    end
  endtask

  task automatic press(input logic snz, input logic dis);
    snooze_btn = snz; dismiss_btn = dis;
    clk1();
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
  endtask

  // Leave the matching minute for one cycle and come back: fresh match edge.
  task automatic retrigger();
    cur_min = 6'd1;
    clk1();
    cur_min = 6'd0;
    clk1();
  endtask

  initial begin
    RST = 1'b1; tick_1hz = 1'b0; cur_hr = 5'd12; cur_min = 6'd0;
    arm_sw = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    clk1(); clk1();
    expect_out("reset", 0, 0, 0, 5'd7, 6'd0); score();

    RST = 1'b0;
    expect_out("idle", 0, 0, 0, 5'd7, 6'd0); clk1(); score();

    expect_out("edit_0003", 0, 0, 0, 5'd0, 6'd3);
    repeat (3) pulse_inc(1'b0, 1'b1);
    repeat (17) pulse_inc(1'b1, 1'b0);
    score();
    expect_out("edit_0059", 0, 0, 0, 5'd0, 6'd59);
    repeat (56) pulse_inc(1'b0, 1'b1);
    score();
    expect_out("edit_both_wrap", 0, 0, 0, 5'd1, 6'd0);
    pulse_inc(1'b1, 1'b1);
    score();
    expect_out("edit_0700", 0, 0, 0, 5'd7, 6'd0);
    repeat (6) pulse_inc(1'b1, 1'b0);
    score();

    arm_sw = 1'b1;
    expect_out("arm", 0, 1, 0, 5'd7, 6'd0); clk1(); score();
    expect_out("pre_match", 0, 1, 0, 5'd7, 6'd0);
    cur_hr = 5'd6; cur_min = 6'd59; clk1(); score();
    expect_out("trigger", 1, 1, 0, 5'd7, 6'd0);
    cur_hr = 5'd7; cur_min = 6'd0; clk1(); score();
    expect_out("ring_4ticks", 1, 1, 0, 5'd7, 6'd0); ticks(RS - 1); score();
    expect_out("autostop", 0, 1, 0, 5'd7, 6'd0); ticks(1); score();
    expect_out("no_retrigger", 0, 1, 0, 5'd7, 6'd0); ticks(10); score();

    expect_out("retrig_a", 1, 1, 0, 5'd7, 6'd0); retrigger(); score();
    expect_out("snooze1", 0, 1, 1, 5'd7, 6'd0); press(1'b1, 1'b0); score();
    expect_out("snooze1_wait", 0, 1, 1, 5'd7, 6'd0); ticks(SS - 1); score();
    expect_out("rering1", 1, 1, 0, 5'd7, 6'd0); ticks(1); score();
    expect_out("snooze2", 0, 1, 1, 5'd7, 6'd0); press(1'b1, 1'b0); score();
    expect_out("rering2", 1, 1, 0, 5'd7, 6'd0); ticks(SS); score();
    expect_out("snooze3_ignored", 1, 1, 0, 5'd7, 6'd0); press(1'b1, 1'b0); score();
    expect_out("dismiss", 0, 1, 0, 5'd7, 6'd0); press(1'b0, 1'b1); score();

    expect_out("retrig_b", 1, 1, 0, 5'd7, 6'd0); retrigger(); score();
    expect_out("snooze_dismiss_same", 0, 1, 0, 5'd7, 6'd0); press(1'b1, 1'b1); score();

    expect_out("retrig_c", 1, 1, 0, 5'd7, 6'd0); retrigger(); score();
    expect_out("inc_hr_in_ring", 1, 1, 0, 5'd7, 6'd0); pulse_inc(1'b1, 1'b0); score();
    expect_out("disarm_ring", 0, 0, 0, 5'd7, 6'd0);
    arm_sw = 1'b0; clk1(); score();

    arm_sw = 1'b1;
    expect_out("rearm", 0, 1, 0, 5'd7, 6'd0); clk1(); score();
    expect_out("edit_armed", 0, 1, 0, 5'd7, 6'd1); pulse_inc(1'b0, 1'b1); score();
    expect_out("no_match_gap", 0, 1, 0, 5'd7, 6'd1); clk1(); score();
    expect_out("edit_match_trigger", 1, 1, 0, 5'd7, 6'd1);
    cur_min = 6'd1; clk1(); score();

    expect_out("async_reset", 0, 0, 0, 5'd7, 6'd0);
    #2 RST = 1'b1;
    #1 score();
    @(negedge CLK);
    RST = 1'b0;
    arm_sw = 1'b0;
    expect_out("post_reset", 0, 0, 0, 5'd7, 6'd0); clk1(); score();

    check_val("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Upstream stage of the LED blinker; produces its `alarmFlag` input.
- Holds a user-set alarm time (hh:mm, 24 h) and compares it against the running clock time.
- Sequences arm / ring / snooze / dismiss, and times ring and snooze intervals on the 1 Hz tick.
- Sits between the timekeeping counters plus debounced buttons and the blinker / 7-segment display mux.

Parameters:
- RING_SECONDS, 60: ticks RINGING lasts before auto-stop.
- SNOOZE_SECONDS, 300: ticks spent in SNOOZE before re-ringing.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; further snooze presses are ignored.
- ALARM_HR_DEF, 7: alarm hour after reset.
- ALARM_MIN_DEF, 0: alarm minute after reset.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-CLK-wide pulse, once per second.
- cur_hr  in  5  current hour, 0-23, binary.
- cur_min  in  6  current minute, 0-59, binary.
- arm_sw  in  1  level; 1 = alarm enabled.
- inc_hr  in  1  one-cycle pulse (debounced upstream); increment alarm hour.
- inc_min  in  1  one-cycle pulse; increment alarm minute.
- snooze_btn  in  1  one-cycle pulse.
- dismiss_btn  in  1  one-cycle pulse.
- alarmFlag  out  1  high while ringing; drives the blinker.
- alm_hr  out  5  stored alarm hour, for display.
- alm_min  out  6  stored alarm minute, for display.
- armed  out  1  high in ARMED, RINGING or SNOOZE.
- snoozing  out  1  high in SNOOZE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; alarmFlag=0, armed=0, snoozing=0.
  - alm_hr=ALARM_HR_DEF, alm_min=ALARM_MIN_DEF.
  - ring_cnt=0, snooze_cnt=0, snooze_num=0, match_q=0.
  - Reset mid-ring drops alarmFlag immediately (asynchronously).
- Match logic:
  - match = (cur_hr==alm_hr) && (cur_min==alm_min); match_q is match registered every CLK.
  - trigger = match && !match_q (rising edge only).
  - After dismiss or timeout, the alarm does not re-trigger within the same matching minute.
- States (all outputs Moore-decoded from the state register):
  - IDLE: arm_sw=1 → ARMED.
  - ARMED: arm_sw=0 → IDLE. trigger → RINGING, with ring_cnt=0 and snooze_num=0.
  - RINGING: alarmFlag=1.
    - dismiss_btn → ARMED.
    - Else snooze_btn with snooze_num<MAX_SNOOZE → SNOOZE; snooze_num+1, snooze_cnt=0.
    - Else tick_1hz with ring_cnt==RING_SECONDS-1 → ARMED (auto-stop).
    - Else tick_1hz → ring_cnt+1.
  - SNOOZE: dismiss_btn → ARMED. tick_1hz with snooze_cnt==SNOOZE_SECONDS-1 → RINGING, ring_cnt=0. Else tick_1hz → snooze_cnt+1.
- Priority, highest first: RST > arm_sw=0 (any state → IDLE next edge) > dismiss_btn > snooze_btn > tick timeout.
- snooze_num clears on entering ARMED or IDLE.
- Latency: trigger evaluated in cycle N → state=RINGING and alarmFlag=1 at the edge ending cycle N (visible in N+1).
- Alarm-time editing:
  - inc_hr / inc_min accepted only in IDLE or ARMED; ignored in RINGING and SNOOZE.
  - inc_hr wraps 23→0; inc_min wraps 59→0 with no carry into hour.
  - Simultaneous inc_hr and inc_min: both apply in the same cycle.
  - Editing the alarm time onto the current time while ARMED creates a match edge and triggers. This is intended.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. snooze_num is $clog2(MAX_SNOOZE+1) bits.
- MAX_SNOOZE=0 disables snooze entirely.

Decomposition:
- Package alarm_pkg:
  - state enum {IDLE, ARMED, RINGING, SNOOZE}, 2-bit encoding.
  - Constants HR_MAX=23, MIN_MAX=59.
  - Widths HR_W=5, MIN_W=6.
- Sub-module alarm_time_reg: holds alm_hr / alm_min, applies gated increments with wrap, and loads reset defaults.
- FSM, counters and match edge detect live in alarm_controller.

Test Plan (RING_SECONDS=5, SNOOZE_SECONDS=3, MAX_SNOOZE=2, defaults 07:00):
- Reset, then 3× inc_min and 17× inc_hr → alm_hr=0 (7+17 wraps), alm_min=3. Then 57× inc_min → alm_min=0.
- arm_sw=1; cur steps 06:59→07:00 → alarmFlag=1 one cycle after the change. Then 5 ticks → alarmFlag=0, state ARMED. Cur held at 07:00 for 10 more ticks → no re-trigger.
- Ringing, snooze_btn → snoozing=1, alarmFlag=0; 3 ticks → ringing again. Second snooze accepted. Third snooze ignored (alarmFlag stays 1).
- Ringing, snooze_btn and dismiss_btn in the same cycle → ARMED, alarmFlag=0, snoozing=0.
- Ringing, arm_sw=0 → IDLE next edge. inc_hr pulsed during RINGING → alm_hr unchanged.
- Assert RST asynchronously between clock edges while alarmFlag=1 → alarmFlag=0 before the next CLK edge; alm time returns to 07:00.
